// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, opcodes,
// ALU op and mux select codes, plus the packed control word.
package mips_ctrl_pkg;

  localparam int unsigned STATE_BITS = 4;
  localparam int unsigned OPCODE_W   = 6;

  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  // alu_op codes, also consumed by the ALU control decoder
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_known_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_main_control_if.sv
// Control/datapath interface: opcode and memory handshake in, strobes and selects out.
interface mc_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational control word decode from current state, opcode and memory handshake.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t                state,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  mem_ready,
  input  logic                  reset,
  output ctrl_t                 ctrl
);

  always_comb begin
    ctrl = '0;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALU_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        // Branch target is precomputed here while the opcode is decoded
        S_DECODE: begin
          ctrl.alu_src_b  = SRCB_IMMSH;
          ctrl.alu_op     = ALU_ADD;
          ctrl.illegal_op = !is_known_op(opcode);
        end
        S_MEMADR, S_ADDIEX: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALU_ADD;
        end
        S_MEMRD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        // Write strobe held through the stall; done only when memory accepts
        S_MEMWR: begin
          ctrl.mem_write  = 1'b1;
          ctrl.i_or_d     = 1'b1;
          ctrl.instr_done = mem_ready;
        end
        S_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_B;
          ctrl.alu_op    = ALU_FUNCT;
        end
        S_RWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        S_BEQ: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_src_b     = SRCB_B;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCSRC_ALUOUT;
          ctrl.instr_done    = 1'b1;
        end
        S_JUMP: begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_source  = PCSRC_JUMP;
          ctrl.instr_done = 1'b1;
        end
        S_ADDIWB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.instr_done = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// the control word decoder driving the datapath interface.
module mc_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  mc_main_control_if.master   bus,
  output logic [STATE_W-1:0]  state
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // mem_ready only matters in FETCH, MEMRD and MEMWR
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (bus.opcode),
    .mem_ready (bus.mem_ready),
    .reset     (reset),
    .ctrl      (ctrl)
  );

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal_op    = ctrl.illegal_op;

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: walks each instruction class cycle by
// cycle and compares state and the full control word to hand-derived values.
module tb_mc_main_control;

  // Control word layout: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
  // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
  // alu_op[1:0], pc_source[1:0], instr_done, illegal_op}
  localparam logic [18:0] W_ZERO   = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] W_F_RDY  = 19'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] W_F_STL  = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [18:0] W_DEC    = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [18:0] W_DECILL = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
  localparam logic [18:0] W_MEMADR = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [18:0] W_MEMRD  = 19'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] W_MEMWB  = 19'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [18:0] W_WR_RDY = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [18:0] W_WR_STL = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [18:0] W_EXEC   = 19'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [18:0] W_RWB    = 19'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [18:0] W_BEQ    = 19'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [18:0] W_JUMP   = 19'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [18:0] W_ADDIEX = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [18:0] W_ADDIWB = 19'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  int         passed = 0;
  int         total  = 0;

  mc_main_control_if bus ();

  mc_main_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  always #5 clk = ~clk;

  wire [18:0] outs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                      bus.pc_source, bus.instr_done, bus.illegal_op};

  task automatic test_reset();
    reset = 1'b1;
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (state !== 4'd0) $display("FAIL reset_state: got %0d exp 0", state);
    else passed++;
    total++;
    if (outs !== W_ZERO) $display("FAIL reset_outs: got %b exp %b", outs, W_ZERO);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    logic [23:0] v [4] = '{{4'd0, 1'b1, W_F_RDY}, {4'd1, 1'b1, W_DEC},
                           {4'd6, 1'b1, W_EXEC}, {4'd7, 1'b1, W_RWB}};
    bus.opcode = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ready = v[i][19];
      #1;
      total++;
      if (state !== v[i][23:20]) $display("FAIL rtype_state row %0d: got %0d exp %0d", i, state, v[i][23:20]);
      else passed++;
      total++;
      if (outs !== v[i][18:0]) $display("FAIL rtype_outs row %0d: got %b exp %b", i, outs, v[i][18:0]);
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if (state !== 4'd0) $display("FAIL rtype_end: got %0d exp 0", state);
    else passed++;
  endtask

  task automatic test_lw_stall();
    logic [23:0] v [10] = '{{4'd0, 1'b0, W_F_STL}, {4'd0, 1'b0, W_F_STL},
                            {4'd0, 1'b1, W_F_RDY}, {4'd1, 1'b1, W_DEC},
                            {4'd2, 1'b0, W_MEMADR}, {4'd3, 1'b0, W_MEMRD},
                            {4'd3, 1'b0, W_MEMRD}, {4'd3, 1'b0, W_MEMRD},
                            {4'd3, 1'b1, W_MEMRD}, {4'd4, 1'b0, W_MEMWB}};
    bus.opcode = 6'b100011;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = v[i][19];
      #1;
      total++;
      if (state !== v[i][23:20]) $display("FAIL lw_state row %0d: got %0d exp %0d", i, state, v[i][23:20]);
      else passed++;
      total++;
      if (outs !== v[i][18:0]) $display("FAIL lw_outs row %0d: got %b exp %b", i, outs, v[i][18:0]);
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if (state !== 4'd0) $display("FAIL lw_end: got %0d exp 0", state);
    else passed++;
  endtask

  task automatic test_sw_stall();
    logic [23:0] v [5] = '{{4'd0, 1'b1, W_F_RDY}, {4'd1, 1'b1, W_DEC},
                           {4'd2, 1'b1, W_MEMADR}, {4'd5, 1'b0, W_WR_STL},
                           {4'd5, 1'b1, W_WR_RDY}};
    bus.opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = v[i][19];
      #1;
      total++;
      if (state !== v[i][23:20]) $display("FAIL sw_state row %0d: got %0d exp %0d", i, state, v[i][23:20]);
      else passed++;
      total++;
      if (outs !== v[i][18:0]) $display("FAIL sw_outs row %0d: got %b exp %b", i, outs, v[i][18:0]);
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if (state !== 4'd0) $display("FAIL sw_end: got %0d exp 0", state);
    else passed++;
  endtask

  task automatic test_beq_j();
    logic [29:0] v [6] = '{{6'b000100, 4'd0, 1'b1, W_F_RDY}, {6'b000100, 4'd1, 1'b0, W_DEC},
                           {6'b000100, 4'd8, 1'b0, W_BEQ},   {6'b000010, 4'd0, 1'b1, W_F_RDY},
                           {6'b000010, 4'd1, 1'b1, W_DEC},   {6'b000010, 4'd9, 1'b0, W_JUMP}};
    for (int i = 0; i < 6; i++) begin
      bus.opcode = v[i][29:24];
      bus.mem_ready = v[i][19];
      #1;
      total++;
      if (state !== v[i][23:20]) $display("FAIL beqj_state row %0d: got %0d exp %0d", i, state, v[i][23:20]);
      else passed++;
      total++;
      if (outs !== v[i][18:0]) $display("FAIL beqj_outs row %0d: got %b exp %b", i, outs, v[i][18:0]);
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if (state !== 4'd0) $display("FAIL beqj_end: got %0d exp 0", state);
    else passed++;
  endtask

  task automatic test_illegal_addi();
    logic [29:0] v [6] = '{{6'b111111, 4'd0, 1'b1, W_F_RDY}, {6'b111111, 4'd1, 1'b1, W_DECILL},
                           {6'b001000, 4'd0, 1'b1, W_F_RDY}, {6'b001000, 4'd1, 1'b0, W_DEC},
                           {6'b001000, 4'd10, 1'b0, W_ADDIEX}, {6'b001000, 4'd11, 1'b1, W_ADDIWB}};
    for (int i = 0; i < 6; i++) begin
      bus.opcode = v[i][29:24];
      bus.mem_ready = v[i][19];
      #1;
      total++;
      if (state !== v[i][23:20]) $display("FAIL illaddi_state row %0d: got %0d exp %0d", i, state, v[i][23:20]);
      else passed++;
      total++;
      if (outs !== v[i][18:0]) $display("FAIL illaddi_outs row %0d: got %b exp %b", i, outs, v[i][18:0]);
      else passed++;
      @(posedge clk); #1;
    end
    total++;
    if (state !== 4'd0) $display("FAIL illaddi_end: got %0d exp 0", state);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [23:0] v [5] = '{{4'd0, 1'b1, W_F_RDY}, {4'd1, 1'b1, W_DEC},
                           {4'd2, 1'b1, W_MEMADR}, {4'd5, 1'b0, W_WR_STL},
                           {4'd5, 1'b0, W_WR_STL}};
    bus.opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = v[i][19];
      #1;
      total++;
      if (state !== v[i][23:20]) $display("FAIL rstmid_state row %0d: got %0d exp %0d", i, state, v[i][23:20]);
      else passed++;
      total++;
      if (outs !== v[i][18:0]) $display("FAIL rstmid_outs row %0d: got %b exp %b", i, outs, v[i][18:0]);
      else passed++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (outs !== W_ZERO) $display("FAIL rstmid_forced: got %b exp %b", outs, W_ZERO);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if (state !== 4'd0) $display("FAIL rstmid_after: got %0d exp 0", state);
    else passed++;
    total++;
    if (outs !== W_F_RDY) $display("FAIL rstmid_fetch: got %b exp %b", outs, W_F_RDY);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (state !== 4'd1) $display("FAIL rstmid_decode: got %0d exp 1", state);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw_stall();
    test_beq_j();
    test_illegal_addi();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
